// File: rtl/nonce_uart_tx_pkg.sv
// rtl/nonce_uart_tx_pkg.sv - shared types and constants for the golden-nonce UART transmitter
// Contents:
//   state_e      serializer FSM state encoding
//   SYNC_BYTE    byte sent ahead of each nonce when the sync option is built in
//   NONCE_BYTES  bytes per nonce
//   COUNT_W      width of the exported queue occupancy
package nonce_uart_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_START = 3'd2,
        ST_DATA  = 3'd3,
        ST_STOP  = 3'd4,
        ST_NEXT  = 3'd5
    } state_e;

    localparam logic [7:0] SYNC_BYTE   = 8'hA5;
    localparam int         NONCE_BYTES = 4;
    localparam int         COUNT_W     = 5;

endpackage

// File: rtl/nonce_uart_tx_if.sv
// rtl/nonce_uart_tx_if.sv - golden-nonce input bundle between hasher and transmitter
// Signals:
//   rx_new_nonce     one-cycle pulse marking a new golden nonce
//   rx_golden_nonce  32-bit nonce, valid with rx_new_nonce
// Modports: master (hasher side, drives), slave (transmitter side, receives)
interface nonce_uart_tx_if;

    logic        rx_new_nonce;
    logic [31:0] rx_golden_nonce;

    modport master (output rx_new_nonce, output rx_golden_nonce);
    modport slave  (input  rx_new_nonce, input  rx_golden_nonce);

endinterface

// File: rtl/nonce_fifo.sv
// rtl/nonce_fifo.sv - synchronous queue with occupancy output
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   push_i, push_data_i     write request and data (ignored when full unless popping)
//   pop_i, pop_data_o       read request and head-of-queue data (head is combinational)
//   count_o, full_o, empty_o occupancy and flags
module nonce_fifo #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 4,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_data_o,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full_o     = (count_q == CNT_W'(DEPTH));
    assign empty_o    = (count_q == '0);
    assign count_o    = count_q;
    assign pop_data_o = mem_q[rd_ptr_q];

    // A push into a full queue still lands when the head leaves in the same cycle.
    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (!full_o || pop_ok);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only read once the pointers say they were written.
    always_ff @(posedge clk) begin
        if (push_ok && !reset) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/nonce_uart_tx.sv
// rtl/nonce_uart_tx.sv - queues golden nonces and sends each one MSB-byte-first as 8N1 UART frames
// Option macro: NONCE_TX_SYNC_EN - when defined, every frame starts with SYNC_BYTE (5 bytes per frame).
// Ports:
//   hash_clk       single clock, rising edge
//   reset          synchronous active-high reset
//   rx             nonce_uart_tx_if.slave: rx_new_nonce pulse + rx_golden_nonce
//   uart_tx        registered serial line, idle high
//   tx_busy        frame in flight or queue non-empty
//   tx_overflow    sticky, a nonce was dropped on a full queue
//   tx_fifo_count  queue occupancy
module nonce_uart_tx
    import nonce_uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                hash_clk,
    input  logic                reset,
    nonce_uart_tx_if.slave      rx,
    output logic                uart_tx,
    output logic                tx_busy,
    output logic                tx_overflow,
    output logic [COUNT_W-1:0]  tx_fifo_count
);

    localparam int CNT_W  = $clog2(CLKS_PER_BIT);
    localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);
`ifdef NONCE_TX_SYNC_EN
    localparam int FRAME_BYTES = NONCE_BYTES + 1;
`else
    localparam int FRAME_BYTES = NONCE_BYTES;
`endif
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    // The stop bit ends one cycle early in STOP; the NEXT cycle supplies its last
    // line-high cycle, so every byte is exactly ten bit periods with no gap.
    localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(CLKS_PER_BIT - 2);
    localparam logic [2:0]       LAST_BYTE = 3'(FRAME_BYTES - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [2:0]        byte_idx_q, byte_idx_d;
    logic [31:0]       word_q, word_d;
    logic [7:0]        shift_q, shift_d;
    logic              tx_q, tx_d;
    logic              ovf_q;

    logic              fifo_pop;
    logic [31:0]       fifo_head;
    logic [FCNT_W-1:0] fifo_count;
    logic              fifo_full;
    logic              fifo_empty;
    logic              bit_done;
    logic              stop_done;
    logic [7:0]        cur_byte;

    nonce_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (hash_clk),
        .reset       (reset),
        .push_i      (rx.rx_new_nonce),
        .push_data_i (rx.rx_golden_nonce),
        .pop_i       (fifo_pop),
        .pop_data_o  (fifo_head),
        .count_o     (fifo_count),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    assign bit_done  = (bit_cnt_q == BIT_LAST);
    assign stop_done = (bit_cnt_q == STOP_LAST);

`ifdef NONCE_TX_SYNC_EN
    assign cur_byte = (byte_idx_q == 3'd0) ? SYNC_BYTE : word_q[31:24];
`else
    assign cur_byte = word_q[31:24];
`endif

    // State register and datapath registers.
    always_ff @(posedge hash_clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            bit_idx_q  <= '0;
            byte_idx_q <= '0;
            word_q     <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            bit_idx_q  <= bit_idx_d;
            byte_idx_q <= byte_idx_d;
            word_q     <= word_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            if (rx.rx_new_nonce && fifo_full && !fifo_pop) ovf_q <= 1'b1;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (!fifo_empty) state_d = ST_LOAD;
            ST_LOAD:  state_d = ST_START;
            ST_START: if (bit_done) state_d = ST_DATA;
            ST_DATA:  if (bit_done && bit_idx_q == 3'd7) state_d = ST_STOP;
            ST_STOP:  if (stop_done) state_d = ST_NEXT;
            ST_NEXT:  state_d = (byte_idx_q == LAST_BYTE) ? ST_IDLE : ST_START;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Outputs; the line value is registered, so it trails the state by one cycle.
    always_comb begin
        fifo_pop = (state_q == ST_LOAD);
        tx_busy  = (state_q != ST_IDLE) || !fifo_empty;
        case (state_q)
            ST_START: tx_d = 1'b0;
            ST_DATA:  tx_d = shift_q[0];
            default:  tx_d = 1'b1;
        endcase
    end

    // Datapath next values.
    always_comb begin
        bit_cnt_d  = '0;
        bit_idx_d  = bit_idx_q;
        byte_idx_d = byte_idx_q;
        word_d     = word_q;
        shift_d    = shift_q;
        if (state_d == state_q &&
            (state_q == ST_START || state_q == ST_DATA || state_q == ST_STOP)) begin
            bit_cnt_d = bit_done ? '0 : bit_cnt_q + 1'b1;
        end
        case (state_q)
            ST_LOAD: begin
                word_d     = fifo_head;
                byte_idx_d = '0;
            end
            ST_START: begin
                shift_d   = cur_byte;
                bit_idx_d = '0;
            end
            ST_DATA: begin
                if (bit_done) begin
                    shift_d   = {1'b0, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 1'b1;
                end
            end
            ST_NEXT: begin
                byte_idx_d = byte_idx_q + 1'b1;
`ifdef NONCE_TX_SYNC_EN
                if (byte_idx_q != 3'd0) word_d = {word_q[23:0], 8'h00};
`else
                word_d = {word_q[23:0], 8'h00};
`endif
            end
            default: ;
        endcase
    end

    assign uart_tx       = tx_q;
    assign tx_overflow   = ovf_q;
    assign tx_fifo_count = COUNT_W'(fifo_count);

endmodule

// File: tb/tb_nonce_uart_tx.sv
// tb/tb_nonce_uart_tx.sv - self-checking bench for nonce_uart_tx
module tb_nonce_uart_tx;

    localparam int C     = 4;
    localparam int DEPTH = 4;
`ifdef NONCE_TX_SYNC_EN
    localparam int FB = 5;
`else
    localparam int FB = 4;
`endif
    localparam int FL = FB * 10 * C;   // frame length in cycles
    localparam int P  = FL + 2;        // pop-to-pop spacing when frames run back to back

    logic       hash_clk = 1'b0;
    logic       reset    = 1'b1;
    logic       uart_tx;
    logic       tx_busy;
    logic       tx_overflow;
    logic [4:0] tx_fifo_count;

    nonce_uart_tx_if rx_if ();

    nonce_uart_tx #(.CLKS_PER_BIT(C), .FIFO_DEPTH(DEPTH)) dut (
        .hash_clk      (hash_clk),
        .reset         (reset),
        .rx            (rx_if),
        .uart_tx       (uart_tx),
        .tx_busy       (tx_busy),
        .tx_overflow   (tx_overflow),
        .tx_fifo_count (tx_fifo_count)
    );

    always #5 hash_clk = ~hash_clk;

    int cyc = 0;
    always @(posedge hash_clk) cyc <= cyc + 1;

    typedef struct { logic [31:0] nonce; int push; int pop; } ent_t;
    typedef struct { logic [7:0] val; int t0; } rxb_t;
    typedef struct { logic [31:0] nonce; int gap; int lat; logic [7:0] b0, b1, b2, b3; } vec_t;

    ent_t        pend[$];
    ent_t        expf[$];
    rxb_t        rxb[$];
    logic [31:0] got[$];
    int          last_pop = -100000;
    int          ovf_edge = 32'h7fffffff;
    int          n_cmp = 0;
    int          n_bad = 0;
    bit          rx_act = 0;
    int          rx_t0;
    logic [7:0]  rx_sh;
    logic [7:0]  last_frame [FB];
    int          last_t0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] byte_of(input logic [31:0] n, input int j);
        int k;
        k = j - (FB - 4);
        if (k < 0) return 8'hA5;
        return n[8*(3-k) +: 8];
    endfunction

    // Reference: a nonce pushed at edge e is popped two edges later, or one frame period
    // after the previous pop if the transmitter is still busy.
    function automatic void model_push(input logic [31:0] n, input int e);
        int occ = 0;
        bit popping = 0;
        int p;
        foreach (pend[i]) begin
            if (pend[i].pop >= e) occ++;
            if (pend[i].pop == e) popping = 1;
        end
        if (occ < DEPTH || popping) begin
            p = (e + 2 > last_pop + P) ? e + 2 : last_pop + P;
            last_pop = p;
            pend.push_back('{n, e, p});
            expf.push_back('{n, e, p});
        end else if (e < ovf_edge) begin
            ovf_edge = e;
        end
    endfunction

    function automatic int exp_count();
        int n = 0;
        foreach (pend[i]) if (pend[i].push <= cyc && cyc < pend[i].pop) n++;
        return n;
    endfunction

    function automatic bit exp_busy();
        foreach (pend[i]) if (pend[i].push <= cyc && cyc < pend[i].pop + FL) return 1;
        return 0;
    endfunction

    task automatic frame_check();
        ent_t        e;
        logic [31:0] n;
        chk("frame_was_expected", expf.size() > 0, 1);
        if (expf.size() > 0) begin
            e = expf.pop_front();
            n = '0;
            for (int j = 0; j < FB; j++) begin
                chk("frame_byte", rxb[j].val, byte_of(e.nonce, j));
                chk("byte_start_cycle", rxb[j].t0, e.pop + 1 + j * 10 * C);
                last_frame[j] = rxb[j].val;
                if (j >= FB - 4) n = {n[23:0], rxb[j].val};
            end
            got.push_back(n);
            last_t0 = rxb[0].t0;
        end
        rxb.delete();
    endtask

    // UART receiver: samples the middle of each bit period.
    task automatic decode();
        int d;
        int k;
        if (!rx_act) begin
            if (uart_tx == 1'b0) begin
                rx_act = 1;
                rx_t0  = cyc;
            end
        end else begin
            d = cyc - rx_t0;
            if (d % C == C / 2) begin
                k = d / C;
                if (k == 0) chk("start_bit", uart_tx, 0);
                else if (k <= 8) rx_sh[k-1] = uart_tx;
                else begin
                    chk("stop_bit", uart_tx, 1);
                    rxb.push_back('{rx_sh, rx_t0});
                    rx_act = 0;
                end
            end
        end
        if (rxb.size() == FB) frame_check();
    endtask

    task automatic step();
        @(negedge hash_clk);
        if (reset) begin
            pend.delete();
            expf.delete();
            rxb.delete();
            rx_act   = 0;
            last_pop = -100000;
            ovf_edge = 32'h7fffffff;
            chk("reset_line", uart_tx, 1);
        end else begin
            decode();
        end
        chk("fifo_count", tx_fifo_count, exp_count());
        chk("busy", tx_busy, exp_busy());
        chk("overflow", tx_overflow, cyc >= ovf_edge);
        while (pend.size() > 0 && pend[0].pop + FL <= cyc) void'(pend.pop_front());
    endtask

    task automatic send(input logic [31:0] n, output int e);
        e = cyc + 1;
        model_push(n, e);
        rx_if.rx_new_nonce    = 1'b1;
        rx_if.rx_golden_nonce = n;
        step();
        rx_if.rx_new_nonce    = 1'b0;
        rx_if.rx_golden_nonce = $urandom();
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic wait_done(input int limit);
        int k = 0;
        while ((pend.size() != 0 || rx_act || rxb.size() != 0) && k < limit) begin
            step();
            k++;
        end
        chk("drain_within_budget", k < limit, 1);
        chk("frames_outstanding", expf.size(), 0);
    endtask

    // Nonces offered during reset must be ignored.
    task automatic do_reset(input int n);
        reset                 = 1'b1;
        rx_if.rx_new_nonce    = 1'b1;
        rx_if.rx_golden_nonce = 32'hFFFF0000;
        repeat (n) step();
        reset                 = 1'b0;
        rx_if.rx_new_nonce    = 1'b0;
        got.delete();
    endtask

    vec_t vecs [6];

    initial begin : main
        int e, e0, e2;
        rx_if.rx_new_nonce    = 1'b0;
        rx_if.rx_golden_nonce = '0;

        vecs[0] = '{32'h12345678, 0, 3, 8'h12, 8'h34, 8'h56, 8'h78};
        vecs[1] = '{32'h00000000, 2, 3, 8'h00, 8'h00, 8'h00, 8'h00};
        vecs[2] = '{32'hFFFFFFFF, 5, 3, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        vecs[3] = '{32'hDEADBEEF, 1, 3, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        vecs[4] = '{32'h0000FFFF, 7, 3, 8'h00, 8'h00, 8'hFF, 8'hFF};
        vecs[5] = '{32'h80000001, 3, 3, 8'h80, 8'h00, 8'h00, 8'h01};

        do_reset(3);
        chk("reset_tx_busy", tx_busy, 0);
        chk("reset_fifo_count", tx_fifo_count, 0);

        // Single frames from the table.
        for (int i = 0; i < 6; i++) begin
            idle(vecs[i].gap);
            send(vecs[i].nonce, e);
            wait_done(1000);
            chk("tbl_latency", last_t0 - e, vecs[i].lat);
            if (FB == 5) chk("tbl_sync_byte", last_frame[0], 8'hA5);
            chk("tbl_byte0", last_frame[FB-4], vecs[i].b0);
            chk("tbl_byte1", last_frame[FB-3], vecs[i].b1);
            chk("tbl_byte2", last_frame[FB-2], vecs[i].b2);
            chk("tbl_byte3", last_frame[FB-1], vecs[i].b3);
            chk("tbl_frame_len", (rxb.size() == 0) && (got.size() == i + 1), 1);
        end

        // Six back-to-back pulses: one in flight, four queued, the sixth dropped.
        do_reset(2);
        for (int i = 1; i <= 6; i++) send(32'(i), e);
        chk("burst_count", tx_fifo_count, 4);
        chk("burst_overflow", tx_overflow, 1);
        wait_done(2000);
        chk("burst_overflow_sticky", tx_overflow, 1);
        chk("burst_frames", got.size(), 5);
        for (int i = 0; i < 5 && i < got.size(); i++) chk("burst_order", got[i], 32'(i + 1));

        // Push into a full queue on the exact edge the head is popped.
        do_reset(2);
        send(32'hA0000001, e0);
        for (int i = 2; i <= 5; i++) send(32'hA0000000 + 32'(i), e);
        while (cyc + 1 < e0 + 2 + P) step();
        send(32'hCAFE0007, e);
        chk("swap_count", tx_fifo_count, 4);
        chk("swap_overflow", tx_overflow, 0);
        wait_done(3000);
        chk("swap_frames", got.size(), 6);
        if (got.size() == 6) chk("swap_last", got[5], 32'hCAFE0007);

        // Reset in the middle of the second byte, with another nonce queued.
        do_reset(2);
        send(32'h12345678, e);
        send(32'h0BADF00D, e2);
        while (cyc < e + 3 + 10 * C + 18) step();
        reset = 1'b1;
        step();
        chk("abort_line", uart_tx, 1);
        chk("abort_count", tx_fifo_count, 0);
        chk("abort_overflow", tx_overflow, 0);
        reset = 1'b0;
        got.delete();
        send(32'hDEADBEEF, e);
        wait_done(1000);
        chk("abort_frames", got.size(), 1);
        if (got.size() == 1) chk("abort_nonce", got[0], 32'hDEADBEEF);

        // Random traffic against the reference model.
        do_reset(2);
        repeat (40) begin
            if ($urandom_range(0, 3) == 0) idle(0);
            else idle($urandom_range(1, 250));
            send($urandom(), e);
        end
        wait_done(20000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
